// File: rtl/fetch_if.sv
// Instruction-memory request channel: fetch issues one request at a time,
// and memory answers with ready and the instruction word in the same cycle.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and
// loads the IF/ID register, absorbing redirects, stalls, flushes and waits.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcselE,
  input  logic [31:0] pc_targetE,
  fetch_if.master     imem,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc4D
);

  // HOLD: a word accepted under stall sits in buf_q.
  // DROP: a request issued before a redirect is still outstanding.
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4d_q, pc4d_d;

  logic [31:0] pc4;
  logic [31:0] target;
  logic        bubble;
  logic        load_mem;
  logic        load_buf;

  assign pc4    = pc_q + 32'd4;
  assign target = pc_targetE & ~32'h3;

  assign imem.imem_req  = !rst && (state_q != HOLD);
  assign imem.imem_addr = pc_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    redir_d  = redir_q;
    bubble   = 1'b0;
    load_mem = 1'b0;
    load_buf = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          if (pcselE) begin
            pc_d   = target;
            bubble = 1'b1;
          end else if (flushD) begin
            pc_d   = pc4;
            bubble = 1'b1;
          end else if (stallD) begin
            buf_d   = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            load_mem = 1'b1;
            pc_d     = pc4;
          end
        end else if (pcselE) begin
          redir_d = target;
          bubble  = 1'b1;
          state_d = DROP;
        end else begin
          bubble = flushD || !stallD;
        end
      end

      HOLD: begin
        if (pcselE) begin
          pc_d    = target;
          bubble  = 1'b1;
          state_d = FETCH;
        end else if (flushD) begin
          pc_d    = pc4;
          bubble  = 1'b1;
          state_d = FETCH;
        end else if (!stallD) begin
          load_buf = 1'b1;
          pc_d     = pc4;
          state_d  = FETCH;
        end
      end

      DROP: begin
        if (pcselE) begin
          redir_d = target;
        end
        if (imem.imem_ready) begin
          pc_d    = pcselE ? target : redir_q;
          state_d = FETCH;
        end
        bubble = pcselE || flushD || !stallD;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc4d_d  = pc4d_q;
    if (bubble) begin
      // Bubble pc of zero is forwarded by decode but never used.
      instr_d = NOP_INSTR;
      pcd_d   = 32'd0;
      pc4d_d  = 32'd0;
    end else if (load_mem) begin
      instr_d = imem.imem_rdata;
      pcd_d   = pc_q;
      pc4d_d  = pc4;
    end else if (load_buf) begin
      instr_d = buf_q;
      pcd_d   = pc_q;
      pc4d_d  = pc4;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= 32'd0;
      redir_q <= 32'd0;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      pc4d_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      redir_q <= redir_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc4d_q  <= pc4d_d;
    end
  end

  assign instrD = instr_q;
  assign pcD    = pcd_q;
  assign pc4D   = pc4d_q;

endmodule
